// File: rtl/mic_capture_ctrl_if.sv
// rtl/mic_capture_ctrl_if.sv - receiver link and FIFO read port bundle for mic_capture_ctrl
interface mic_capture_ctrl_if #(
    parameter int DATA_W  = 18,
    parameter int FIFO_AW = 4
);
    logic              mic_en;
    logic              mic_done;
    logic [DATA_W-1:0] mic_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              empty;
    logic              full;
    logic [FIFO_AW:0]  level;

    modport master (
        output mic_en,
        input  mic_done, mic_data,
        input  rd_en,
        output rd_data, empty, full, level
    );

    modport slave (
        input  mic_en,
        output mic_done, mic_data,
        output rd_en,
        input  rd_data, empty, full, level
    );
endinterface

// File: rtl/mic_capture_ctrl.sv
// rtl/mic_capture_ctrl.sv - I2S mic capture sequencer with show-ahead sample FIFO (optional watchdog: MIC_CTRL_TIMEOUT_EN)
module mic_capture_ctrl #(
    parameter int DATA_W  = 18,
    parameter int FIFO_AW = 4,
    parameter int CNT_W   = 16
`ifdef MIC_CTRL_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 65535
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             fifo_clr,
    output logic             busy,
    output logic             cap_done,
    output logic             overflow,
    output logic             timeout,
    mic_capture_ctrl_if.master bus
);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT, S_FINISH, S_REARM} state_t;

    state_t              state, next_state;
    logic                done_q;
    logic [CNT_W-1:0]    remaining;
    logic                cont;
    logic [FIFO_AW:0]    wr_ptr, rd_ptr;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                overflow_q;
    logic                mic_edge, sample_wr, last_sample, start_ok;
    logic                fifo_empty, fifo_full, do_rd, do_wr;
    logic                wd_fire;

    assign mic_edge    = bus.mic_done & ~done_q;
    assign sample_wr   = (state == S_WAIT) && mic_edge;
    assign last_sample = sample_wr && !cont && (remaining == CNT_W'(1));
    assign start_ok    = (state == S_IDLE) && start && !stop;

    // Extra pointer bit distinguishes full from empty when the low bits match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                        (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign do_rd      = bus.rd_en && !fifo_empty && !fifo_clr;
    assign do_wr      = sample_wr && (!fifo_full || do_rd) && !fifo_clr;

    assign bus.empty   = fifo_empty;
    assign bus.full    = fifo_full;
    assign bus.level   = wr_ptr - rd_ptr;
    assign bus.rd_data = fifo_empty ? '0 : mem[rd_ptr[FIFO_AW-1:0]];
    assign bus.mic_en  = (state == S_ARM) || (state == S_WAIT);
    assign busy        = (state != S_IDLE);
    assign cap_done    = (state == S_FINISH);
    assign overflow    = overflow_q;

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[FIFO_AW-1:0]] <= bus.mic_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_q <= 1'b0;
        end else if (fifo_clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            if (sample_wr && fifo_full && !do_rd) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            done_q    <= 1'b0;
            remaining <= '0;
            cont      <= 1'b0;
        end else begin
            state  <= next_state;
            done_q <= bus.mic_done;
            if (start_ok) begin
                remaining <= num_samples;
                cont      <= (num_samples == '0);
            end else if (sample_wr && !cont) begin
                remaining <= remaining - 1'b1;
            end
        end
    end

`ifdef MIC_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            timeout_q;

    assign wd_fire = (state == S_WAIT) && !mic_edge && !stop &&
                     (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
    assign timeout = timeout_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state != S_WAIT || mic_edge) wd_cnt <= '0;
            else                             wd_cnt <= wd_cnt + 1'b1;
            if (start_ok)     timeout_q <= 1'b0;
            else if (wd_fire) timeout_q <= 1'b1;
        end
    end
`else
    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start_ok) next_state = S_ARM;
            S_ARM:    next_state = stop ? S_IDLE : S_WAIT;
            S_WAIT: begin
                if (stop)             next_state = S_IDLE;
                else if (last_sample) next_state = S_FINISH;
                else if (wd_fire)     next_state = S_REARM;
            end
            S_FINISH: next_state = S_IDLE;
            S_REARM:  next_state = stop ? S_IDLE : S_ARM;
            default:  next_state = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_mic_capture_ctrl.sv
// tb/tb_mic_capture_ctrl.sv - scoreboard bench for mic_capture_ctrl
module tb_mic_capture_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        start, stop, fifo_clr;
    logic [15:0] num_samples;
    logic        busy, cap_done, overflow, timeout;

    int total = 0;
    int bad   = 0;
    int cap_cnt = 0;
    logic [17:0] exp_q[$];

    mic_capture_ctrl_if #(.DATA_W(18), .FIFO_AW(4)) bus();

`ifdef MIC_CTRL_TIMEOUT_EN
    mic_capture_ctrl #(.TIMEOUT_CYC(100)) dut (
`else
    mic_capture_ctrl dut (
`endif
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .num_samples(num_samples), .fifo_clr(fifo_clr), .busy(busy),
        .cap_done(cap_done), .overflow(overflow), .timeout(timeout), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Pops are observed mid-cycle: rd_en with a non-empty FIFO means the head is consumed.
    always @(negedge clk) begin
        if (reset && bus.rd_en && !bus.empty) begin
            if (exp_q.size() == 0) chk("pop_unexpected", {14'd0, bus.rd_data}, 32'hFFFF_FFFF);
            else                   chk("pop_data", {14'd0, bus.rd_data}, {14'd0, exp_q.pop_front()});
        end
        if (reset && cap_done) cap_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] n);
        num_samples = n;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
    endtask

    task automatic send(input logic [17:0] d, input bit stored);
        bus.mic_data = d;
        bus.mic_done = 1'b1;
        if (stored) exp_q.push_back(d);
        tick();
        bus.mic_done = 1'b0;
        tick();
    endtask

    task automatic pop_n(input int n);
        bus.rd_en = 1'b1;
        repeat (n) tick();
        bus.rd_en = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; fifo_clr = 1'b0; num_samples = '0;
        bus.mic_done = 1'b0; bus.mic_data = '0; bus.rd_en = 1'b0;
        repeat (3) tick();
        chk("rst_mic_en", {31'd0, bus.mic_en}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_cap_done", {31'd0, cap_done}, 0);
        chk("rst_empty", {31'd0, bus.empty}, 1);
        chk("rst_full", {31'd0, bus.full}, 0);
        chk("rst_level", {27'd0, bus.level}, 0);
        chk("rst_overflow", {31'd0, overflow}, 0);
        chk("rst_timeout", {31'd0, timeout}, 0);
        chk("rst_rd_data", {14'd0, bus.rd_data}, 0);
        reset = 1'b1;
        tick();

        do_start(16'd4);
        chk("arm_mic_en", {31'd0, bus.mic_en}, 1);
        chk("arm_busy", {31'd0, busy}, 1);
        for (int i = 1; i <= 4; i++) send(18'(i), 1'b1);
        tick();
        chk("fin_cap_cnt", cap_cnt, 1);
        chk("fin_level", {27'd0, bus.level}, 4);
        chk("fin_busy", {31'd0, busy}, 0);
        chk("fin_mic_en", {31'd0, bus.mic_en}, 0);
        pop_n(4);
        chk("fin_empty", {31'd0, bus.empty}, 1);

        do_start(16'd0);
        for (int i = 0; i < 16; i++) send(18'h10 + 18'(i), 1'b1);
        chk("cont_full", {31'd0, bus.full}, 1);
        chk("cont_level16", {27'd0, bus.level}, 16);
        chk("cont_ovf0", {31'd0, overflow}, 0);
        bus.mic_data = 18'h100;
        bus.mic_done = 1'b1;
        bus.rd_en = 1'b1;
        exp_q.push_back(18'h100);
        tick();
        bus.mic_done = 1'b0;
        bus.rd_en = 1'b0;
        tick();
        chk("coinc_ovf", {31'd0, overflow}, 0);
        chk("coinc_level", {27'd0, bus.level}, 16);
        chk("coinc_head", {14'd0, bus.rd_data}, 32'h11);
        for (int i = 0; i < 4; i++) send(18'h3F000 + 18'(i), 1'b0);
        chk("drop_ovf", {31'd0, overflow}, 1);
        chk("drop_level", {27'd0, bus.level}, 16);
        chk("drop_busy", {31'd0, busy}, 1);
        do_stop();
        chk("stop_mic_en", {31'd0, bus.mic_en}, 0);
        chk("stop_busy", {31'd0, busy}, 0);
        chk("stop_no_cap", cap_cnt, 1);
        pop_n(16);
        chk("drain_empty", {31'd0, bus.empty}, 1);
        fifo_clr = 1'b1;
        tick();
        fifo_clr = 1'b0;
        chk("clr_ovf", {31'd0, overflow}, 0);

        do_start(16'd0);
        bus.mic_data = 18'h2AAAA;
        bus.mic_done = 1'b1;
        exp_q.push_back(18'h2AAAA);
        repeat (10) tick();
        bus.mic_done = 1'b0;
        tick();
        chk("held_level", {27'd0, bus.level}, 1);
        do_stop();
        pop_n(1);
        pop_n(1);
        chk("rd_empty_level", {27'd0, bus.level}, 0);
        chk("rd_empty_empty", {31'd0, bus.empty}, 1);

        do_start(16'd5);
        send(18'h21, 1'b1);
        send(18'h22, 1'b1);
        do_stop();
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_no_cap", cap_cnt, 1);
        do_start(16'd3);
        for (int i = 3; i <= 5; i++) send(18'h20 + 18'(i), 1'b1);
        tick();
        chk("rerun_cap", cap_cnt, 2);
        chk("rerun_level", {27'd0, bus.level}, 5);
        pop_n(5);

        do_start(16'd0);
        bus.mic_data = 18'h7;
        bus.mic_done = 1'b1;
        fifo_clr = 1'b1;
        tick();
        bus.mic_done = 1'b0;
        fifo_clr = 1'b0;
        tick();
        chk("clr_discard_level", {27'd0, bus.level}, 0);
        do_stop();

`ifdef MIC_CTRL_TIMEOUT_EN
        begin
            int k;
            do_start(16'd0);
            k = 0;
            for (int i = 1; i <= 200; i++) begin
                tick();
                if (!bus.mic_en) begin
                    k = i;
                    break;
                end
            end
            chk("wd_cycles", k, 100);
            chk("wd_flag", {31'd0, timeout}, 1);
            tick();
            chk("wd_rearm", {31'd0, bus.mic_en}, 1);
            do_stop();
        end
`endif

        do_start(16'd0);
        send(18'h3, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_mic_en", {31'd0, bus.mic_en}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_empty", {31'd0, bus.empty}, 1);
        chk("arst_level", {27'd0, bus.level}, 0);
        chk("arst_rd_data", {14'd0, bus.rd_data}, 0);
        chk("arst_timeout", {31'd0, timeout}, 0);
        tick();
        reset = 1'b1;
        tick();

        chk("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
